// File: rtl/adam_pause_sequencer_pkg.sv
// Shared types for the pause sequencer: FSM state encoding and index sizing.
package adam_pause_sequencer_pkg;

    typedef enum logic [2:0] {
        RUN,
        PAUSE_TGT,
        RST_ON,
        PAUSED,
        RST_HOLD,
        RESUME_TGT
    } state_t;

    // Index width never collapses to zero bits, even for a single target.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adam_pause_sequencer_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module adam_pause_sequencer_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/adam_pause_sequencer.sv
// Pauses targets in reverse order, pulses their resets, and resumes them in forward order,
// one req/ack handshake at a time, with a shared timer for the reset window and ack timeouts.
module adam_pause_sequencer
    import adam_pause_sequencer_pkg::*;
#(
    parameter int NO_TGTS    = 4,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pause_req,
    output logic                              pause_ack,
    input  logic [NO_TGTS-1:0]                en_mask,
    output logic [NO_TGTS-1:0]                tgt_rst,
    output logic [NO_TGTS-1:0]                tgt_pause_req,
    input  logic [NO_TGTS-1:0]                tgt_pause_ack,
    output logic                              busy,
    output logic                              timeout_err,
    output logic [idx_width(NO_TGTS)-1:0]     timeout_idx,
    input  logic                              err_clr
);

    localparam int IDX_W = idx_width(NO_TGTS);
    localparam int TMAX  = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t        LAST_IDX  = idx_t'(NO_TGTS - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(RST_CYCLES - 1);

    state_t              state, state_next;
    idx_t                idx, idx_next, idx_dn, idx_up;
    logic [NO_TGTS-1:0]  mask, mask_next;
    logic [NO_TGTS-1:0]  rst_next, req_next;
    logic                err_next;
    idx_t                err_idx_next;
    logic                timer_load, timer_expired;
    logic [TW-1:0]       timer_val;

    assign idx_dn = idx - idx_t'(1);
    assign idx_up = idx + idx_t'(1);

    adam_pause_sequencer_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PAUSED;
            idx           <= '0;
            mask          <= '0;
            tgt_rst       <= '1;
            tgt_pause_req <= '1;
            timeout_err   <= 1'b0;
            timeout_idx   <= '0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            mask          <= mask_next;
            tgt_rst       <= rst_next;
            tgt_pause_req <= req_next;
            timeout_err   <= err_next;
            timeout_idx   <= err_idx_next;
        end
    end

    // Every handshake step reloads the timer, so the ack wait restarts per target.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        mask_next    = mask;
        rst_next     = tgt_rst;
        req_next     = tgt_pause_req;
        err_next     = timeout_err;
        err_idx_next = timeout_idx;
        timer_load   = 1'b0;
        timer_val    = TO_LOAD;

        if (err_clr) begin
            err_next     = 1'b0;
            err_idx_next = '0;
        end

        case (state)
            RUN: begin
                if (pause_req) begin
                    mask_next  = en_mask;
                    idx_next   = LAST_IDX;
                    state_next = PAUSE_TGT;
                    timer_load = 1'b1;
                    if (en_mask[LAST_IDX]) req_next[LAST_IDX] = 1'b1;
                end
            end
            PAUSE_TGT: begin
                if (!mask[idx] || tgt_pause_ack[idx] || timer_expired) begin
                    if (mask[idx] && !tgt_pause_ack[idx]) begin
                        err_next     = 1'b1;
                        err_idx_next = idx;
                    end
                    timer_load = 1'b1;
                    if (idx == '0) begin
                        state_next = RST_ON;
                        rst_next   = tgt_rst | mask;
                    end else begin
                        idx_next = idx_dn;
                        if (mask[idx_dn]) req_next[idx_dn] = 1'b1;
                    end
                end
            end
            RST_ON: begin
                state_next = PAUSED;
            end
            PAUSED: begin
                if (!pause_req) begin
                    mask_next  = en_mask;
                    state_next = RST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = HOLD_LOAD;
                end
            end
            RST_HOLD: begin
                if (timer_expired) begin
                    rst_next   = tgt_rst & ~mask;
                    idx_next   = '0;
                    state_next = RESUME_TGT;
                    timer_load = 1'b1;
                    if (mask[0]) req_next[0] = 1'b0;
                end
            end
            RESUME_TGT: begin
                if (!mask[idx] || !tgt_pause_ack[idx] || timer_expired) begin
                    if (mask[idx] && tgt_pause_ack[idx]) begin
                        err_next     = 1'b1;
                        err_idx_next = idx;
                    end
                    timer_load = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = RUN;
                    end else begin
                        idx_next = idx_up;
                        if (mask[idx_up]) req_next[idx_up] = 1'b0;
                    end
                end
            end
            default: begin
                state_next = PAUSED;
            end
        endcase
    end

    assign busy      = (state != RUN) && (state != PAUSED);
    assign pause_ack = (state == PAUSED) || (state == RST_HOLD) || (state == RESUME_TGT);

endmodule
